// File: rtl/rotor_refresh_sequencer_if.sv
// rotor_refresh_sequencer_if: move-request valid/ready handshake between a cell controller and the rotor sequencer.
interface rotor_refresh_sequencer_if #(
  parameter int IDX_W = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_rotor;
  logic [7:0]       req_state;
  modport master (output req_valid, req_rotor, req_state, input req_ready);
  modport slave (input req_valid, req_rotor, req_state, output req_ready);
endinterface

// File: rtl/rotor_refresh_sequencer.sv
// rotor_refresh_sequencer: one-at-a-time Braille rotor mover (LUT lookup, step/dir pulses, settle, commit); STATE_READBACK_EN adds rd_rotor/rd_state.
module rotor_refresh_sequencer #(
  parameter int         N_ROTORS    = 6,
  parameter int         IDX_W       = 3,
  parameter int         STEP_HI_CYC = 4,
  parameter int         STEP_LO_CYC = 4,
  parameter int         SETTLE_CYC  = 16,
  parameter logic [7:0] RESET_STATE = 8'hC0
) (
  input  logic                      clk,
  input  logic                      rst,
  rotor_refresh_sequencer_if.slave  req,
  output logic [7:0]                lut_current_state,
  output logic [7:0]                lut_next_state,
  input  logic [7:0]                lut_angle,
  output logic [IDX_W-1:0]          rotor_sel,
  output logic                      step,
  output logic                      dir,
  output logic                      busy,
  output logic                      done,
  output logic                      err
`ifdef STATE_READBACK_EN
  ,
  input  logic [IDX_W-1:0]          rd_rotor,
  output logic [7:0]                rd_state
`endif
);
  localparam int MAX_HL = STEP_HI_CYC > STEP_LO_CYC ? STEP_HI_CYC : STEP_LO_CYC;
  localparam int MAX_C  = MAX_HL > SETTLE_CYC ? MAX_HL : SETTLE_CYC;
  localparam int TMR_W  = $clog2(MAX_C + 1);
  typedef enum logic [2:0] {IDLE, LOOKUP, STEP_HI, STEP_LO, SETTLE, COMMIT} state_e;
  state_e           st_q;
  state_e           post_d;
  logic [7:0]       rot_q [N_ROTORS];
  logic [7:0]       cnt_q;
  logic [TMR_W-1:0] tmr_q;
  logic [7:0]       mag_d;
  logic             accept_d;
  logic             in_range_d;
  logic             cmt_d;
  assign req.req_ready = st_q == IDLE;
  assign busy = st_q != IDLE;
  always_comb begin
    accept_d   = req.req_valid && st_q == IDLE;
    in_range_d = int'(req.req_rotor) < N_ROTORS;
    mag_d      = lut_angle[7] ? -lut_angle : lut_angle;
    post_d     = SETTLE_CYC == 0 ? COMMIT : SETTLE;
    cmt_d      = (post_d == COMMIT && ((st_q == LOOKUP && mag_d == 8'd0) ||
                  (st_q == STEP_LO && tmr_q == '0 && cnt_q == 8'd1))) ||
                 (st_q == SETTLE && tmr_q == '0);
  end
  // The rotor state is written on entry to COMMIT so readback sees it right after COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q              <= IDLE;
      cnt_q             <= 8'd0;
      tmr_q             <= '0;
      step              <= 1'b0;
      dir               <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      rotor_sel         <= '0;
      lut_current_state <= 8'd0;
      lut_next_state    <= 8'd0;
      for (int i = 0; i < N_ROTORS; i++) rot_q[i] <= RESET_STATE;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (st_q)
        IDLE: if (accept_d) begin
          if (in_range_d) begin
            st_q              <= LOOKUP;
            rotor_sel         <= req.req_rotor;
            lut_current_state <= rot_q[req.req_rotor];
            lut_next_state    <= req.req_state;
          end else err <= 1'b1;
        end
        LOOKUP: begin
          dir   <= lut_angle[7];
          cnt_q <= mag_d;
          if (mag_d != 8'd0) begin
            st_q  <= STEP_HI;
            step  <= 1'b1;
            tmr_q <= TMR_W'(STEP_HI_CYC - 1);
          end else begin
            st_q  <= post_d;
            tmr_q <= TMR_W'(SETTLE_CYC - 1);
          end
        end
        STEP_HI: if (tmr_q == '0) begin
          st_q  <= STEP_LO;
          step  <= 1'b0;
          tmr_q <= TMR_W'(STEP_LO_CYC - 1);
        end else tmr_q <= tmr_q - TMR_W'(1);
        STEP_LO: if (tmr_q == '0) begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            st_q  <= post_d;
            tmr_q <= TMR_W'(SETTLE_CYC - 1);
          end else begin
            st_q  <= STEP_HI;
            step  <= 1'b1;
            tmr_q <= TMR_W'(STEP_HI_CYC - 1);
          end
        end else tmr_q <= tmr_q - TMR_W'(1);
        SETTLE: if (tmr_q == '0) st_q <= COMMIT;
                else tmr_q <= tmr_q - TMR_W'(1);
        COMMIT: st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
      if (cmt_d) begin
        rot_q[rotor_sel] <= lut_next_state;
        done             <= 1'b1;
      end
    end
  end
`ifdef STATE_READBACK_EN
  always_ff @(posedge clk)
    rd_state <= rst ? 8'h00 : (int'(rd_rotor) < N_ROTORS ? rot_q[rd_rotor] : 8'h00);
`endif
endmodule

// File: tb/tb_rotor_refresh_sequencer.sv
// tb_rotor_refresh_sequencer: randomized self-checking bench for rotor_refresh_sequencer against a move-level reference model.
module tb_rotor_refresh_sequencer;
  localparam int N = 6, HI = 4, LO = 4, SET = 16;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] lut_current_state, lut_next_state, lut_angle;
  logic [2:0] rotor_sel;
  logic       step, dir, busy, done, err;
  logic [7:0] model [N];
  int         checks = 0, failures = 0, done_cnt = 0;
`ifdef STATE_READBACK_EN
  logic [2:0] rd_rotor = 3'd0;
  logic [7:0] rd_state;
`endif
  rotor_refresh_sequencer_if #(.IDX_W(3)) rif ();
  rotor_refresh_sequencer #(
    .N_ROTORS(N), .IDX_W(3), .STEP_HI_CYC(HI), .STEP_LO_CYC(LO),
    .SETTLE_CYC(SET), .RESET_STATE(8'hC0)
  ) dut (
    .clk(clk), .rst(rst), .req(rif),
    .lut_current_state(lut_current_state), .lut_next_state(lut_next_state),
    .lut_angle(lut_angle), .rotor_sel(rotor_sel), .step(step), .dir(dir),
    .busy(busy), .done(done), .err(err)
`ifdef STATE_READBACK_EN
    , .rd_rotor(rd_rotor), .rd_state(rd_state)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  task automatic issue(input logic [2:0] r, input logic [7:0] s, input logic [7:0] a);
    int w = 0;
    @(negedge clk);
    rif.req_valid = 1'b1;
    rif.req_rotor = r;
    rif.req_state = s;
    lut_angle     = a;
    while (rif.req_ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (rif.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready got=%b exp=1", rif.req_ready);
    end
  endtask
  task automatic track(input logic [2:0] r, input logic [7:0] s, input logic [7:0] a, input bit hold,
                       input logic [2:0] r2, input logic [7:0] s2, input logic [7:0] a2);
    int   exp_n, exp_lat, n_pulse, hi_run, lo_run, bad, done_at;
    logic prev;
    exp_n = int'($signed(a));
    if (exp_n < 0) exp_n = -exp_n;
    exp_lat = 1 + exp_n * (HI + LO) + SET + 1;
    n_pulse = 0; hi_run = 0; lo_run = 0; bad = 0; done_at = 0; prev = 1'b0;
    for (int c = 1; c <= 3000 && done_at == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({lut_current_state, lut_next_state, rotor_sel, busy, rif.req_ready} !== {model[r], s, r, 2'b10}) begin
          failures++;
          $display("FAIL lookup got cur=%h next=%h sel=%0d busy=%b rdy=%b exp cur=%h next=%h sel=%0d busy=1 rdy=0",
                   lut_current_state, lut_next_state, rotor_sel, busy, rif.req_ready, model[r], s, r);
        end
        if (hold) begin
          rif.req_rotor = r2;
          rif.req_state = s2;
        end else rif.req_valid = 1'b0;
      end
      if (c == 2 && hold) lut_angle = a2;
      if (step === 1'b1) begin
        if (prev !== 1'b1) begin
          n_pulse++;
          if (n_pulse > 1 && lo_run != LO) bad++;
          lo_run = 0;
        end
        hi_run++;
        if (dir !== a[7] || rotor_sel !== r || busy !== 1'b1) bad++;
      end else begin
        if (prev === 1'b1) begin
          if (hi_run != HI) bad++;
          hi_run = 0;
        end
        lo_run++;
      end
      prev = step;
      if (done === 1'b1) begin
        done_at = c;
        if (dir !== a[7] || rotor_sel !== r || busy !== 1'b1) bad++;
      end
    end
    checks++;
    if (done_at != exp_lat) begin
      failures++;
      $display("FAIL latency rotor=%0d angle=%h got=%0d exp=%0d", r, a, done_at, exp_lat);
    end
    checks++;
    if (n_pulse != exp_n) begin
      failures++;
      $display("FAIL pulse_count rotor=%0d angle=%h got=%0d exp=%0d", r, a, n_pulse, exp_n);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL pulse_shape rotor=%0d angle=%h bad_cycles=%0d exp=0", r, a, bad);
    end
    model[r] = s;
  endtask
`ifdef STATE_READBACK_EN
  task automatic test_readback();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd_rotor = 3'(i);
      @(negedge clk);
      checks++;
      if (rd_state !== (i < N ? model[i] : 8'h00)) begin
        failures++;
        $display("FAIL readback rotor=%0d got=%h exp=%h", i, rd_state, (i < N ? model[i] : 8'h00));
      end
    end
  endtask
`endif
  task automatic test_reset();
    rst = 1'b1;
    rif.req_valid = 1'b0;
    rif.req_rotor = 3'd0;
    rif.req_state = 8'h00;
    lut_angle = 8'h00;
    for (int i = 0; i < N; i++) model[i] = 8'hC0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({step, dir, busy, done, err, rif.req_ready, rotor_sel, lut_current_state, lut_next_state} !==
        {6'b000001, 3'd0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_outputs got step=%b dir=%b busy=%b done=%b err=%b rdy=%b sel=%0d lut=%h/%h exp 0,0,0,0,0,1,0,00/00",
               step, dir, busy, done, err, rif.req_ready, rotor_sel, lut_current_state, lut_next_state);
    end
`ifdef STATE_READBACK_EN
    test_readback();
`endif
  endtask
  task automatic test_negative_move();
    issue(3'd2, 8'h00, 8'hF7);
    track(3'd2, 8'h00, 8'hF7, 1'b0, 3'd0, 8'h00, 8'h00);
  endtask
  task automatic test_zero_move();
    issue(3'd2, 8'h00, 8'h00);
    track(3'd2, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00);
    issue(3'd5, 8'h3C, 8'h00);
    track(3'd5, 8'h3C, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00);
  endtask
  task automatic test_out_of_range(input logic [2:0] r);
    issue(r, 8'hAA, 8'h05);
    @(negedge clk);
    rif.req_valid = 1'b0;
    checks++;
    if ({err, busy, step, rif.req_ready} !== 4'b1001) begin
      failures++;
      $display("FAIL oor_pulse rotor=%0d got err=%b busy=%b step=%b rdy=%b exp 1,0,0,1", r, err, busy, step, rif.req_ready);
    end
    @(negedge clk);
    checks++;
    if ({err, busy, step} !== 3'b000) begin
      failures++;
      $display("FAIL oor_after rotor=%0d got err=%b busy=%b step=%b exp 0,0,0", r, err, busy, step);
    end
  endtask
  task automatic test_max_magnitude();
    issue(3'd3, 8'h12, 8'h80);
    track(3'd3, 8'h12, 8'h80, 1'b1, 3'd4, 8'h34, 8'h00);
    @(negedge clk);
    checks++;
    if ({rif.req_ready, busy, done} !== 3'b100) begin
      failures++;
      $display("FAIL ready_after_done got rdy=%b busy=%b done=%b exp 1,0,0", rif.req_ready, busy, done);
    end
    track(3'd4, 8'h34, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00);
  endtask
  task automatic test_reset_mid_move();
    int   np = 0;
    int   d0;
    logic prev = 1'b0;
    issue(3'd1, 8'h55, 8'h05);
    for (int c = 0; c < 200 && np < 3; c++) begin
      @(negedge clk);
      if (c == 0) rif.req_valid = 1'b0;
      if (step === 1'b1 && prev !== 1'b1) np++;
      prev = step;
    end
    checks++;
    if (np != 3) begin
      failures++;
      $display("FAIL third_pulse got=%0d exp=3", np);
    end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 8'hC0;
    checks++;
    if ({step, busy, done, rif.req_ready, rotor_sel, lut_current_state, lut_next_state} !== {4'b0001, 3'd0, 16'h0000}) begin
      failures++;
      $display("FAIL midreset_outputs got step=%b busy=%b done=%b rdy=%b sel=%0d lut=%h/%h exp 0,0,0,1,0,00/00",
               step, busy, done, rif.req_ready, rotor_sel, lut_current_state, lut_next_state);
    end
    repeat (120) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      failures++;
      $display("FAIL midreset_done got=%0d exp=%0d", done_cnt, d0);
    end
`ifdef STATE_READBACK_EN
    test_readback();
`endif
    issue(3'd1, 8'h66, 8'h00);
    track(3'd1, 8'h66, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00);
    issue(3'd2, 8'h11, 8'h02);
    track(3'd2, 8'h11, 8'h02, 1'b0, 3'd0, 8'h00, 8'h00);
  endtask
  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      logic [2:0] r;
      logic [7:0] s, a;
      int v;
      r = 3'($urandom_range(0, 7));
      s = 8'($urandom);
      v = int'($urandom_range(0, 12)) - 6;
      a = 8'(v);
      if (r >= 3'(N)) test_out_of_range(r);
      else begin
        issue(r, s, a);
        track(r, s, a, 1'b0, 3'd0, 8'h00, 8'h00);
      end
    end
`ifdef STATE_READBACK_EN
    test_readback();
`endif
  endtask
  initial begin
    test_reset();
    test_negative_move();
`ifdef STATE_READBACK_EN
    test_readback();
`endif
    test_zero_move();
    test_out_of_range(3'd7);
    test_out_of_range(3'd6);
    test_max_magnitude();
    test_reset_mid_move();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rotor_refresh_sequencer.md
Name: rotor_refresh_sequencer

Overview:
- Sequences rotor moves for the Braille refresh display, one rotor at a time.
- Holds the current 8-bit state of every rotor and accepts "move rotor R to state S" requests over a valid/ready handshake.
- For each request it queries the external angle lookup table with {current, next}, then emits step/dir pulses for the signed angle and waits out a settle time.
- After the settle time it commits the new state and pulses done.

Parameters:
- N_ROTORS, 6: number of rotors (one Braille cell).
- IDX_W, 3: rotor index width; must satisfy 2^IDX_W >= N_ROTORS.
- STEP_HI_CYC, 4: clk cycles step is held high per pulse; minimum 1.
- STEP_LO_CYC, 4: clk cycles step is held low per pulse; minimum 1.
- SETTLE_CYC, 16: clk cycles to wait after the last pulse before commit; 0 is allowed.
- RESET_STATE, 8'hC0: value loaded into every rotor state register on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request; high only in IDLE.
- req_rotor  in  IDX_W  target rotor index.
- req_state  in  8  requested next state.
- lut_current_state  out  8  current state presented to the angle LUT.
- lut_next_state  out  8  next state presented to the angle LUT.
- lut_angle  in  8  LUT result, two's-complement step count; combinational from the lut_* outputs.
- rotor_sel  out  IDX_W  rotor the step/dir pins are routed to.
- step  out  1  step pulse to the selected rotor driver.
- dir  out  1  1 = negative rotation, 0 = positive rotation.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a move commits.
- err  out  1  one-cycle pulse when a request names an out-of-range rotor.

Behaviour:
- Reset (rst high at a clk edge, from any state, including mid-pulse):
  - FSM goes to IDLE.
  - All rotor states load RESET_STATE.
  - step=0, dir=0, done=0, err=0, busy=0, rotor_sel=0, lut_* =0, req_ready=1 from the next cycle.
  - An in-progress move is abandoned and its state is not committed.
- FSM states: IDLE, LOOKUP, STEP_HI, STEP_LO, SETTLE, COMMIT.
- IDLE:
  - req_ready=1. A request is accepted when req_valid && req_ready.
  - On accept, req_rotor and req_state are registered.
  - If req_rotor >= N_ROTORS: err pulses the next cycle, the FSM stays in IDLE, no state changes.
  - Otherwise go to LOOKUP.
- LOOKUP (exactly 1 cycle):
  - lut_current_state = state[rotor]; lut_next_state = registered next state. Both are registered outputs.
  - lut_angle is captured at the end of the cycle.
  - dir = angle[7]. Magnitude = |angle| as 8-bit unsigned, so 8'h80 gives 128 steps.
  - Magnitude 0 goes to SETTLE; otherwise go to STEP_HI.
- STEP_HI: step=1 for STEP_HI_CYC cycles, then go to STEP_LO.
- STEP_LO: step=0 for STEP_LO_CYC cycles, then decrement the remaining count. Go to STEP_HI if the count is nonzero, else SETTLE.
- SETTLE: step=0 for SETTLE_CYC cycles (0 means pass straight through to COMMIT), then go to COMMIT.
- COMMIT (1 cycle): state[rotor] <= next, done=1, then return to IDLE.
- rotor_sel and dir are stable from LOOKUP through COMMIT and hold their last value in IDLE.
- Accept-to-done latency for N steps: 1 + N*(STEP_HI_CYC+STEP_LO_CYC) + SETTLE_CYC + 1 cycles, counting LOOKUP as cycle 1.
- Back-to-back requests:
  - req_ready returns high in the cycle after COMMIT.
  - req_valid held high while busy is not accepted and is not lost; the requester keeps it asserted.
- A request with next == current is processed normally; the LUT returns 0, giving no steps, then settle and commit.

Optional Feature:
- Macro: STATE_READBACK_EN.
- Defined: adds input rd_rotor [IDX_W] and output rd_state [8].
  - rd_state is registered: it equals state[rd_rotor] one cycle after rd_rotor is sampled.
  - Out-of-range rd_rotor returns 8'h00.
  - A COMMIT write is visible on readback in the cycle after COMMIT.
- Undefined: neither port exists and all other behaviour is identical.

Test Plan:
- Reset then readback: assert rst, release, read all rotors (STATE_READBACK_EN) -> every rotor reads 8'hC0; step=0, busy=0, req_ready=1.
- Negative move: bench LUT returns 8'hF7 for {C0,00}; request rotor 2 -> 8'h00 -> lut ports show C0/00 in LOOKUP, dir=1, rotor_sel=2, 9 step pulses each 4 cycles high and 4 low. done comes 1+72+16+1 = 90 cycles after accept; rotor 2 then reads 8'h00.
- Zero-angle move: LUT returns 8'h00 -> no step pulses; done exactly 18 cycles after accept; state committed.
- Out-of-range rotor: req_rotor=7 with N_ROTORS=6 -> one err pulse, no busy, no step, all states unchanged.
- Max magnitude: LUT returns 8'h80 -> exactly 128 pulses with dir=1. A second request held valid during the move is accepted in the cycle after done.
- Reset mid-move: assert rst during the 3rd step pulse -> step=0 next cycle, FSM in IDLE, rotor state is 8'hC0 (not committed), no done pulse.
